// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and
// load/store. Data accesses win over fetches; the pipeline is frozen until
// both the current fetch and the current data access have completed.
//
// state | meaning
// IDLE  | no access in flight; issue pending data first, else pending fetch
// REQ   | request presented, waiting for mem_gnt; fields held from sel
// WAIT  | request accepted, waiting for mem_rvalid to capture the response
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  dm_re,
    input  logic                  dm_we,
    input  logic [ADDR_W-1:0]     dm_addr,
    input  logic [DATA_W-1:0]     dm_wdata,
    input  logic [DATA_W/8-1:0]   dm_wmask,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [DATA_W-1:0]     instr_rdata,
    output logic [DATA_W-1:0]     dm_rdata,
    output logic                  stallF,
    output logic                  stallD,
    output logic                  stallE,
    output logic                  stallM,
    output logic                  flushW
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;
    typedef enum logic {SEL_INSTR, SEL_DATA} sel_t;

    state_t            st;
    sel_t              sel;
    sel_t              sel_cur;
    logic              i_done;
    logic              d_done;
    logic [DATA_W-1:0] instr_q;
    logic [DATA_W-1:0] dmrd_q;
    logic              data_pend;
    logic              fetch_pend;
    logic              any_pend;
    logic              hold;

    assign data_pend  = (dm_re | dm_we) & ~d_done;
    assign fetch_pend = if_req & ~i_done;
    assign any_pend   = data_pend | fetch_pend;

    // Gated by rst_n so the freeze and the request drop the instant reset asserts.
    assign hold   = rst_n & any_pend;
    assign stallF = hold;
    assign stallD = hold;
    assign stallE = hold;
    assign stallM = hold;
    assign flushW = hold;

    assign instr_rdata = instr_q;
    assign dm_rdata    = dmrd_q;

    // Source selection: decided live in IDLE, taken from the latched sel afterwards.
    always_comb begin
        sel_cur = sel;
        if (st == ST_IDLE) begin
            sel_cur = data_pend ? SEL_DATA : SEL_INSTR;
        end
    end

    // Request strobe and field mux toward memory.
    always_comb begin
        mem_req = rst_n & (((st == ST_IDLE) & any_pend) | (st == ST_REQ));
        if (sel_cur == SEL_DATA) begin
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
            mem_wmask = dm_wmask;
        end else begin
            mem_we    = 1'b0;
            mem_addr  = if_addr;
            mem_wdata = '0;
            mem_wmask = '0;
        end
    end

    // Access sequencing, completion flags and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= ST_IDLE;
            sel     <= SEL_INSTR;
            i_done  <= 1'b0;
            d_done  <= 1'b0;
            instr_q <= '0;
            dmrd_q  <= '0;
        end else begin
            // Completion flags live for one instruction; the freeze lifting retires it.
            if (!hold) begin
                i_done <= 1'b0;
                d_done <= 1'b0;
            end
            case (st)
                ST_IDLE: begin
                    if (any_pend) begin
                        sel <= sel_cur;
                        st  <= mem_gnt ? ST_WAIT : ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        st <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        st <= ST_IDLE;
                        if (sel == SEL_INSTR) begin
                            i_done  <= 1'b1;
                            instr_q <= mem_rdata;
                        end else begin
                            d_done <= 1'b1;
                            // A store's response is only an acknowledge; re+we counts as a store.
                            if (dm_re & ~dm_we) begin
                                dmrd_q <= mem_rdata;
                            end
                        end
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a behavioural memory with
// programmable grant/response delays, expected requests and expected
// pipeline-advance records queued by the stimulus, checked by a monitor.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_re;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wmask;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] instr_rdata;
    logic [31:0] dm_rdata;
    logic        stallF;
    logic        stallD;
    logic        stallE;
    logic        stallM;
    logic        flushW;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .dm_re       (dm_re),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_wmask    (dm_wmask),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wmask   (mem_wmask),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .instr_rdata (instr_rdata),
        .dm_rdata    (dm_rdata),
        .stallF      (stallF),
        .stallD      (stallD),
        .stallE      (stallE),
        .stallM      (stallM),
        .flushW      (flushW)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } req_t;

    typedef struct {
        int          cycles;
        logic [31:0] instr;
        logic [31:0] dmrd;
    } adv_t;

    req_t req_q[$];
    adv_t adv_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;

    // memory-model controls (one-shot delays, consumed when used)
    int          gnt_dly = 0;
    int          rv_dly = 0;
    logic        spur = 1'b0;
    int          rs = 0;
    int          wcnt = 0;
    logic [31:0] lat_addr = '0;
    logic        lat_we = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0013;
            32'h0000_0004: return 32'h0010_0093;
            32'h0000_0008: return 32'h0020_8113;
            32'h0000_0020: return 32'h00C0_0193;
            32'h0000_0040: return 32'h0400_0213;
            32'h0000_0100: return 32'hDEAD_BEEF;
            default:       return 32'hCAFE_F00D;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Memory responder: acts 2 time units after each rising edge, once DUT outputs settle.
    initial begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                rs = 0; wcnt = 0; gnt_dly = 0; rv_dly = 0;
                mem_gnt = 1'b0; mem_rvalid = 1'b0;
            end else if (rs == 0) begin
                mem_rvalid = spur;
                if (spur) mem_rdata = 32'hBAD0_BAD0;
                spur = 1'b0;
                if (mem_req && wcnt == gnt_dly) begin
                    mem_gnt = 1'b1;
                    lat_addr = mem_addr;
                    lat_we = mem_we;
                    rs = 1; wcnt = 0; gnt_dly = 0;
                end else begin
                    mem_gnt = 1'b0;
                    if (mem_req) wcnt++;
                end
            end else begin
                mem_gnt = 1'b0;
                if (wcnt == rv_dly) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = lat_we ? 32'h55AA_55AA : mem_word(lat_addr);
                    rs = 0; wcnt = 0; rv_dly = 0;
                end else begin
                    mem_rvalid = 1'b0;
                    wcnt++;
                end
            end
        end
    end

    // Monitor: compares issued requests and pipeline advances against the queues.
    always @(negedge clk) begin
        req_t r;
        adv_t a;
        if (rst_n) begin
            chk("stall_bus", {27'd0, stallD, stallE, stallM, flushW, 1'b0},
                {27'd0, {4{stallF}}, 1'b0});
            if (mem_req && req_q.size() > 0) begin
                r = req_q[0];
                chk("req_addr",  mem_addr,  r.addr);
                chk("req_we",    {31'd0, mem_we}, {31'd0, r.we});
                chk("req_wdata", mem_wdata, r.wdata);
                chk("req_wmask", {28'd0, mem_wmask}, {28'd0, r.wmask});
                if (mem_gnt) void'(req_q.pop_front());
            end else if (mem_req && mem_gnt && adv_q.size() > 0) begin
                chk("unexpected_req", mem_addr, 32'hFFFF_FFFF);
            end
            if (!stallF && adv_q.size() > 0) begin
                a = adv_q.pop_front();
                chk("adv_cycle", cyc - start_cyc, a.cycles);
                chk("instr_rdata", instr_rdata, a.instr);
                chk("dm_rdata", dm_rdata, a.dmrd);
                chk("reqs_left", req_q.size(), 0);
            end
        end
    end

    task automatic start_instr(input logic [31:0] pc, input logic re, input logic we,
                               input logic [31:0] da, input logic [31:0] wd, input logic [3:0] wm,
                               input int gd, input int rd,
                               input int exp_cyc, input logic [31:0] exp_i, input logic [31:0] exp_d);
        req_t r;
        adv_t a;
        if_req   = 1'b1;
        if_addr  = pc;
        dm_re    = re;
        dm_we    = we;
        dm_addr  = da;
        dm_wdata = wd;
        dm_wmask = wm;
        gnt_dly  = gd;
        rv_dly   = rd;
        if (re || we) begin
            r.addr = da; r.we = we; r.wdata = wd; r.wmask = wm;
            req_q.push_back(r);
        end
        r.addr = pc; r.we = 1'b0; r.wdata = '0; r.wmask = '0;
        req_q.push_back(r);
        a.cycles = exp_cyc; a.instr = exp_i; a.dmrd = exp_d;
        adv_q.push_back(a);
        start_cyc = cyc;
    endtask

    task automatic wait_adv(input string name);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (adv_q.size() != 0 && n < 100);
        if (adv_q.size() != 0) begin
            chk({name, "_timeout"}, n, 0);
            adv_q.delete();
            req_q.delete();
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        if_req   = 1'b1;
        if_addr  = 32'h0;
        dm_re    = 1'b1;
        dm_we    = 1'b0;
        dm_addr  = 32'h100;
        dm_wdata = '0;
        dm_wmask = '0;
        #3;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_hold", {31'd0, stallF}, 32'd0);
        chk("rst_instr", instr_rdata, 32'd0);
        chk("rst_dmrd", dm_rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // fetch-only, zero-wait
        start_instr(32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 2, 32'h0000_0013, 32'h0);
        wait_adv("fetch0");
        start_instr(32'h4, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 2, 32'h0010_0093, 32'h0);
        wait_adv("fetch4");
        start_instr(32'h8, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 2, 32'h0020_8113, 32'h0);
        wait_adv("fetch8");

        // load plus fetch: data first
        start_instr(32'h20, 1, 0, 32'h100, 32'h0, 4'h0, 0, 0, 4, 32'h00C0_0193, 32'hDEAD_BEEF);
        wait_adv("load");

        // store with grant withheld two cycles
        start_instr(32'h24, 0, 1, 32'h104, 32'h1234_5678, 4'b0011, 2, 0, 6, 32'hCAFE_F00D, 32'hDEAD_BEEF);
        wait_adv("store");

        // load and store both set behaves as a store
        start_instr(32'h28, 1, 1, 32'h108, 32'hA5A5_A5A5, 4'hF, 0, 0, 4, 32'hCAFE_F00D, 32'hDEAD_BEEF);
        wait_adv("re_we");

        // delayed grant and response, spurious rvalid while IDLE
        start_instr(32'h40, 0, 0, 32'h0, 32'h0, 4'h0, 1, 3, 6, 32'h0400_0213, 32'hDEAD_BEEF);
        spur = 1'b1;
        wait_adv("spur");

        // reset in the middle of WAIT
        start_instr(32'h8, 0, 0, 32'h0, 32'h0, 4'h0, 0, 5, 7, 32'h0020_8113, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("midrst_hold", {31'd0, flushW}, 32'd0);
        chk("midrst_instr", instr_rdata, 32'd0);
        chk("midrst_dmrd", dm_rdata, 32'd0);
        req_q.delete();
        adv_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        start_instr(32'h4, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 2, 32'h0010_0093, 32'h0);
        wait_adv("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
